// File: rtl/ram_resp_slave_pkg.sv
// Shared transfer-type encodings and line geometry for the cache<->RAM
// request interface.
package ram_resp_slave_pkg;

  typedef enum logic [2:0] {
    XFER_BYTE = 3'b000,
    XFER_HALF = 3'b001,
    XFER_WORD = 3'b010,
    XFER_LINE = 3'b100
  } xfer_e;

  localparam int LINE_WORDS = 4;

  // Every code other than LINE behaves as a single-word access.
  function automatic logic is_line(input logic [2:0] t);
    return t == XFER_LINE;
  endfunction

endpackage

// File: rtl/ram_resp_slave_if.sv
// Cache<->RAM request bus: the cache drives requests (master), the RAM
// responder returns ready/data (slave).
interface ram_resp_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    rd_req_i;
  logic [2:0]              rd_type_i;
  logic [ADDR_WIDTH-1:0]   rd_addr_i;
  logic                    rd_rdy_o;
  logic [DATA_WIDTH-1:0]   rd_data_o;
  logic                    rd_valid_o;
  logic                    rd_last_o;
  logic                    wr_rdy_o;
  logic                    wr_req_i;
  logic [2:0]              wr_type_i;
  logic [3:0]              wr_en_i;
  logic [ADDR_WIDTH-1:0]   wr_addr_i;
  logic [4*DATA_WIDTH-1:0] wr_data_i;

  modport master (
    output rd_req_i, rd_type_i, rd_addr_i,
    output wr_req_i, wr_type_i, wr_en_i, wr_addr_i, wr_data_i,
    input  rd_rdy_o, rd_data_o, rd_valid_o, rd_last_o, wr_rdy_o
  );

  modport slave (
    input  rd_req_i, rd_type_i, rd_addr_i,
    input  wr_req_i, wr_type_i, wr_en_i, wr_addr_i, wr_data_i,
    output rd_rdy_o, rd_data_o, rd_valid_o, rd_last_o, wr_rdy_o
  );
endinterface

// File: rtl/ram_resp_slave_sram_sp.sv
// Single-port synchronous RAM: byte-lane masked write, registered read.
// Contents are never cleared; only the read register honours reset.
module sram_sp #(
  parameter int MEM_AW     = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int LW = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][b*LW +: LW] <= wdata[b*LW +: LW];
      end
    end
    if (rst) rdata_q <= '0;
    else if (en && !we) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_resp_slave.sv
// RAM responder behind the data cache: serves masked/line writes and
// returns single-beat or 4-beat line read bursts from a local SRAM.
module ram_resp_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int RD_DELAY   = 0
) (
  input  logic             clk,
  input  logic             rst,
  ram_resp_slave_if.slave  bus
);
  import ram_resp_slave_pkg::*;

  localparam int WCW = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_BURST, S_WR_LINE} state_e;

  state_e                                 state_q, state_d;
  logic [1:0]                             beat_q, beat_d;
  logic [WCW-1:0]                         wait_q, wait_d;
  logic [MEM_AW-1:0]                      rd_idx_q, rd_idx_d;
  logic                                   rd_line_q, rd_line_d;
  logic [MEM_AW-3:0]                      wr_base_q, wr_base_d;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  wr_line_q, wr_line_d;
  logic                                   rd_valid_q, rd_valid_d;
  logic                                   rd_last_q, rd_last_d;

  logic [ADDR_WIDTH-1:0]                  rd_addr, wr_addr;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  wr_words;
  logic [MEM_AW-1:0]                      wr_idx;
  logic                                   rd_rdy, wr_rdy, rd_acc, wr_acc;
  logic                                   mem_en, mem_we;
  logic [3:0]                             mem_be;
  logic [MEM_AW-1:0]                      mem_addr;
  logic [DATA_WIDTH-1:0]                  mem_wdata, mem_rdata;
  logic                                   unused_addr;

  assign rd_addr     = bus.rd_addr_i;
  assign wr_addr     = bus.wr_addr_i;
  assign wr_words    = bus.wr_data_i;
  assign wr_idx      = wr_addr[MEM_AW+1:2];
  assign unused_addr = ^{rd_addr, wr_addr};

  // Ready stays low through the last-beat cycle so a new request waits one more cycle.
  assign wr_rdy = (state_q == S_IDLE) && !rd_last_q;
  assign rd_rdy = wr_rdy && !bus.wr_req_i;
  assign wr_acc = bus.wr_req_i && wr_rdy;
  assign rd_acc = bus.rd_req_i && rd_rdy;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    rd_idx_d   = rd_idx_q;
    rd_line_d  = rd_line_q;
    wr_base_d  = wr_base_q;
    wr_line_d  = wr_line_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'h0;
    mem_addr   = rd_idx_q;
    mem_wdata  = wr_words[0];
    case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          if (is_line(bus.wr_type_i)) begin
            mem_be    = 4'hF;
            mem_addr  = {wr_idx[MEM_AW-1:2], 2'b00};
            wr_base_d = wr_idx[MEM_AW-1:2];
            wr_line_d = wr_words;
            beat_d    = 2'd1;
            state_d   = S_WR_LINE;
          end else begin
            mem_be   = bus.wr_en_i;
            mem_addr = wr_idx;
          end
        end else if (rd_acc) begin
          rd_idx_d  = rd_addr[MEM_AW+1:2];
          rd_line_d = is_line(bus.rd_type_i);
          beat_d    = 2'd0;
          wait_d    = '0;
          state_d   = (RD_DELAY == 0) ? S_RD_BURST : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == WCW'(RD_DELAY - 1)) state_d = S_RD_BURST;
        else wait_d = wait_q + 1'b1;
      end
      S_RD_BURST: begin
        mem_en     = 1'b1;
        mem_addr   = rd_line_q ? {rd_idx_q[MEM_AW-1:2], beat_q} : rd_idx_q;
        rd_valid_d = 1'b1;
        beat_d     = beat_q + 2'd1;
        if (!rd_line_q || beat_q == 2'(LINE_WORDS - 1)) begin
          rd_last_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WR_LINE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_be    = 4'hF;
        mem_addr  = {wr_base_q, beat_q};
        mem_wdata = wr_line_q[beat_q];
        beat_d    = beat_q + 2'd1;
        if (beat_q == 2'(LINE_WORDS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= 2'd0;
      wait_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
    rd_idx_q  <= rd_idx_d;
    rd_line_q <= rd_line_d;
    wr_base_q <= wr_base_d;
    wr_line_q <= wr_line_d;
  end

  // A write pending at a reset edge is dropped along with the rest of the line.
  sram_sp #(.MEM_AW(MEM_AW), .DATA_WIDTH(DATA_WIDTH)) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (mem_we && !rst),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.rd_rdy_o   = rd_rdy;
  assign bus.wr_rdy_o   = wr_rdy;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_last_o  = rd_last_q;
  assign bus.rd_data_o  = mem_rdata;
endmodule
